// File: rtl/nibble_serial_adder.sv
// nibble_serial_adder: sequences a WIDTH-bit add through an external 4-bit adder slice, LSB nibble first.
// Define NSA_SIGNED_OVF_EN to add the registered two's-complement overflow output ovf.
module nibble_serial_adder #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             c_in,
    output logic [3:0]       sl_a,
    output logic [3:0]       sl_b,
    output logic             sl_cin,
    input  logic [3:0]       sl_sum,
    input  logic             sl_cout,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             c_out,
`ifdef NSA_SIGNED_OVF_EN
    output logic             ovf,
`endif
    output logic             busy
);
    localparam int NSL = WIDTH / 4;
    localparam int IW = NSL > 1 ? $clog2(NSL) : 1;
    localparam logic [IW-1:0] LAST = IW'(NSL - 1);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t           state, state_nx;
    logic [WIDTH-1:0] a_reg, b_reg;
    logic [IW-1:0]    idx;
    logic             carry, accept, last;

    always_comb begin
        in_ready  = state == IDLE && !rst;
        out_valid = state == DONE;
        busy      = state != IDLE;
        accept    = in_valid && in_ready;
        last      = state == RUN && idx == LAST;
        sl_a      = state == RUN ? a_reg[{idx, 2'b00} +: 4] : 4'h0;
        sl_b      = state == RUN ? b_reg[{idx, 2'b00} +: 4] : 4'h0;
        sl_cin    = state == RUN ? carry : 1'b0;
        state_nx  = accept                        ? RUN  :
                    last                          ? DONE :
                    (state == DONE && out_ready)  ? IDLE : state;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            idx   <= '0;
            carry <= 1'b0;
            a_reg <= '0;
            b_reg <= '0;
            sum   <= '0;
            c_out <= 1'b0;
        end else begin
            state <= state_nx;
            if (accept) begin
                a_reg <= a;
                b_reg <= b;
                carry <= c_in;
                idx   <= '0;
            end
            // sum keeps the previous result until each nibble is overwritten
            if (state == RUN) begin
                sum[{idx, 2'b00} +: 4] <= sl_sum;
                carry <= sl_cout;
                idx   <= idx + IW'(1);
                if (last)
                    c_out <= sl_cout;
            end
        end
    end

`ifdef NSA_SIGNED_OVF_EN
    always_ff @(posedge clk) begin
        if (rst)
            ovf <= 1'b0;
        else if (last)
            ovf <= (a_reg[WIDTH-1] == b_reg[WIDTH-1]) && (sl_sum[3] != a_reg[WIDTH-1]);
    end
`endif
endmodule

// File: tb/tb_nibble_serial_adder.sv
// tb_nibble_serial_adder: table, hand-written and random checks of nibble_serial_adder at WIDTH=16.
module tb_nibble_serial_adder;
    logic        clk = 0, rst = 1, in_valid = 0, c_in = 0, out_ready = 0;
    logic [15:0] a = '0, b = '0, sum;
    logic [3:0]  sl_a, sl_b, sl_sum;
    logic        sl_cin, sl_cout, in_ready, out_valid, c_out, busy;
`ifdef NSA_SIGNED_OVF_EN
    logic        ovf;
`endif
    int passed = 0, total = 0;
    logic [3:0] sa_q[$];
    logic       sc_q[$];

    always #5 clk = ~clk;

    // behavioural 4-bit adder slice the sequencer drives
    assign {sl_cout, sl_sum} = 5'(sl_a) + 5'(sl_b) + 5'(sl_cin);

    nibble_serial_adder #(.WIDTH(16)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .c_in(c_in),
        .sl_a(sl_a), .sl_b(sl_b), .sl_cin(sl_cin), .sl_sum(sl_sum), .sl_cout(sl_cout),
        .out_valid(out_valid), .out_ready(out_ready), .sum(sum), .c_out(c_out),
`ifdef NSA_SIGNED_OVF_EN
        .ovf(ovf),
`endif
        .busy(busy)
    );

    typedef struct {
        logic [15:0] a, b;
        logic        cin;
        int          hold;
        logic [15:0] sum;
        logic        cout, ovf;
    } vec_t;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h", name, got, exp);
    endtask

    task automatic do_op(input logic [15:0] x, input logic [15:0] y, input logic ci, input int hold,
                         input logic [15:0] es, input logic eco, input logic eov);
        int lat;
        sa_q.delete();
        sc_q.delete();
        @(negedge clk);
        chk("in_ready_idle", in_ready, 1);
        a = x; b = y; c_in = ci; in_valid = 1;
        @(negedge clk);
        in_valid = 0; a = 16'($urandom); b = 16'($urandom); c_in = 1'($urandom);
        lat = 0;
        while (!out_valid && lat < 20) begin
            sa_q.push_back(sl_a);
            sc_q.push_back(sl_cin);
            @(negedge clk);
            lat++;
        end
        chk("latency", lat, 4);
        chk("sum", sum, es);
        chk("c_out", c_out, eco);
`ifdef NSA_SIGNED_OVF_EN
        chk("ovf", ovf, eov);
`endif
        for (int i = 0; i < hold; i++) begin
            in_valid = 1; a = 16'($urandom); b = 16'($urandom);
            @(negedge clk);
            chk("hold_valid", out_valid, 1);
            chk("hold_sum", sum, es);
            chk("hold_in_ready", in_ready, 0);
            chk("done_sl_a", sl_a, 0);
        end
        in_valid = 0; out_ready = 1;
        @(negedge clk);
        out_ready = 0;
        chk("release_valid", out_valid, 0);
        chk("release_in_ready", in_ready, 1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        vec_t        vecs[7];
        logic [3:0]  exp_sa[4];
        logic        exp_sc[4];
        logic [15:0] x, y, s;
        logic        ci, co, ov, seen;

        vecs[0] = '{16'h1234, 16'h4321, 1'b0, 0, 16'h5555, 1'b0, 1'b0};
        vecs[1] = '{16'hFFFF, 16'h0001, 1'b0, 0, 16'h0000, 1'b1, 1'b0};
        vecs[2] = '{16'hFFFF, 16'h0000, 1'b1, 0, 16'h0000, 1'b1, 1'b0};
        vecs[3] = '{16'h0000, 16'h0000, 1'b1, 0, 16'h0001, 1'b0, 1'b0};
        vecs[4] = '{16'hA5A5, 16'h0000, 1'b0, 3, 16'hA5A5, 1'b0, 1'b0};
        vecs[5] = '{16'h7FFF, 16'h0001, 1'b0, 0, 16'h8000, 1'b0, 1'b1};
        vecs[6] = '{16'h8000, 16'h8000, 1'b0, 1, 16'h0000, 1'b1, 1'b1};
        exp_sa = '{4'h4, 4'h3, 4'h2, 4'h1};
        exp_sc = '{1'b0, 1'b1, 1'b1, 1'b1};

        repeat (2) @(negedge clk);
        chk("rst_in_ready", in_ready, 0);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_sum", sum, 0);
        chk("rst_c_out", c_out, 0);
        chk("rst_sl", {sl_a, sl_b, sl_cin}, 0);
        rst = 0;

        foreach (vecs[i])
            do_op(vecs[i].a, vecs[i].b, vecs[i].cin, vecs[i].hold, vecs[i].sum, vecs[i].cout, vecs[i].ovf);

        do_op(16'h1234, 16'h4321, 1'b0, 0, 16'h5555, 1'b0, 1'b0);
        chk("sl_a_count", sa_q.size(), 4);
        for (int i = 0; i < 4 && i < sa_q.size(); i++) chk("sl_a_seq", sa_q[i], exp_sa[i]);
        do_op(16'hFFFF, 16'h0001, 1'b0, 0, 16'h0000, 1'b1, 1'b0);
        chk("sl_cin_count", sc_q.size(), 4);
        for (int i = 0; i < 4 && i < sc_q.size(); i++) chk("sl_cin_seq", sc_q[i], exp_sc[i]);

        @(negedge clk);
        a = 16'h1234; b = 16'h0001; c_in = 0; in_valid = 1;
        @(negedge clk);
        in_valid = 0;
        repeat (2) @(negedge clk);
        chk("mid_busy", busy, 1);
        chk("mid_sl_a", sl_a, 4'h2);
        rst = 1;
        @(negedge clk);
        chk("midrst_busy", busy, 0);
        chk("midrst_out_valid", out_valid, 0);
        chk("midrst_in_ready", in_ready, 0);
        chk("midrst_sl_a", sl_a, 0);
        rst = 0;
        #1;
        chk("postrst_in_ready", in_ready, 1);
        seen = 0;
        repeat (6) begin
            @(negedge clk);
            seen |= out_valid;
        end
        chk("postrst_no_valid", seen, 0);
        do_op(16'h0001, 16'h0001, 1'b0, 0, 16'h0002, 1'b0, 1'b0);

        repeat (30) begin
            x  = 16'($urandom);
            y  = 16'($urandom);
            ci = 1'($urandom);
            {co, s} = {1'b0, x} + {1'b0, y} + 17'(ci);
            ov = (x[15] == y[15]) && (s[15] != x[15]);
            do_op(x, y, ci, $urandom_range(0, 2), s, co, ov);
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
